// File: rtl/nrda_pkg.sv
// Shared types and sizing helpers for the nrda_seq_div sequential divider.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   state_t    - divider control states
//   calc_n     - clocks spent in CALC for a given width / iterations-per-clock
//   calc_cnt_w - width of the CALC iteration counter, sized to hold 0..N
package nrda_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      CORR = 2'd2,
      DONE = 2'd3
   } state_t;

   function automatic int calc_n(input int width, input int steps);
      return width / steps;
   endfunction

   function automatic int calc_cnt_w(input int width, input int steps);
      return $clog2((width / steps) + 1);
   endfunction

endpackage

// File: rtl/nrda_seq_div_step.sv
// One non-restoring division iteration on the partial remainder P and dividend A.
// Latency: purely combinational.
// Backpressure: none; chained STEPS_PER_CYCLE times inside nrda_seq_div.
//
// Ports:
//   p      - partial remainder, WIDTH+1 bits, two's complement
//   a      - dividend / quotient shift register
//   d      - divisor magnitude
//   p_nxt  - partial remainder after this iteration
//   a_nxt  - A shifted left with the new quotient bit inserted at bit 0
module nrda_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   p,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH:0]   p_nxt,
   output logic [WIDTH-1:0] a_nxt
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] d_ext;

   // {P, A[MSB]} is WIDTH+2 bits in principle; keeping only WIDTH+1 bits is
   // safe because the true result of the add/subtract lies in [-D, D), which
   // fits, so modular arithmetic gives the exact value.
   assign shifted = {p[WIDTH-1:0], a[WIDTH-1]};
   assign d_ext   = {1'b0, d};

   always_comb begin
      p_nxt = shifted - d_ext;
      if (p[WIDTH]) begin
         p_nxt = shifted + d_ext;
      end
      a_nxt = {a[WIDTH-2:0], ~p_nxt[WIDTH]};
   end

endmodule

// File: rtl/nrda_seq_div.sv
// Sequential non-restoring divider: q = x / y, r = x % y, STEPS_PER_CYCLE bits per clock.
// Latency: WIDTH/STEPS_PER_CYCLE + 2 edges from accept to out_valid; 1 edge for y == 0.
// Backpressure: result held in DONE until out_ready; in_ready only asserted in IDLE.
//
// Ports:
//   clk, rst_n            - rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   - operand handshake; x, y (and sgn) sampled on accept only
//   out_valid / out_ready - result handshake; q, r, div_by_zero stable while waiting
//   div_by_zero           - result came from y == 0 (q = all ones, r = x)
//   sgn                   - two's complement operands; exists only with NRDA_SIGNED_EN
//
// Optional feature macro: NRDA_SIGNED_EN (signed mode, truncating toward zero).
module nrda_seq_div
   import nrda_pkg::*;
#(
   parameter int WIDTH           = 32,
   parameter int STEPS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
`ifdef NRDA_SIGNED_EN
   input  logic             sgn,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             div_by_zero
);

   localparam int N  = calc_n(WIDTH, STEPS_PER_CYCLE);
   localparam int CW = calc_cnt_w(WIDTH, STEPS_PER_CYCLE);
   localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

   if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
      $error("nrda_seq_div: WIDTH must be >= 4 and even");
   end
   if (!(STEPS_PER_CYCLE == 1 || STEPS_PER_CYCLE == 2 || STEPS_PER_CYCLE == 4) ||
       (WIDTH % STEPS_PER_CYCLE) != 0) begin : g_bad_steps
      $error("nrda_seq_div: STEPS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH");
   end

   state_t state_q, state_d;

   logic [WIDTH:0]   p_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] d_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] r_q;
   logic             dz_q;

   logic             y_zero;
   logic [WIDTH-1:0] a_init;
   logic [WIDTH-1:0] d_init;
   logic [WIDTH:0]   p_fix;
   logic [WIDTH-1:0] q_fin;
   logic [WIDTH-1:0] r_fin;

   assign y_zero = (y == '0);

   // ------------------------------------------------------------------
   // Operand preparation and final sign correction
   // ------------------------------------------------------------------
   // The core always divides magnitudes; signed mode remembers which of
   // the two results must be negated once the division is finished.
`ifdef NRDA_SIGNED_EN
   logic x_neg, y_neg;
   logic neg_q_q, neg_r_q;

   assign x_neg  = sgn & x[WIDTH-1];
   assign y_neg  = sgn & y[WIDTH-1];
   // The most-negative value negates to itself, which read as unsigned is
   // exactly its magnitude, so it needs no special case.
   assign a_init = x_neg ? (~x + 1'b1) : x;
   assign d_init = y_neg ? (~y + 1'b1) : y;
`else
   assign a_init = x;
   assign d_init = y;
`endif

   // A negative final remainder is restored by adding D back once.
   always_comb begin
      p_fix = p_q;
      if (p_q[WIDTH]) begin
         p_fix = p_q + {1'b0, d_q};
      end
`ifdef NRDA_SIGNED_EN
      q_fin = neg_q_q ? (~a_q + 1'b1) : a_q;
      r_fin = neg_r_q ? (~p_fix[WIDTH-1:0] + 1'b1) : p_fix[WIDTH-1:0];
`else
      q_fin = a_q;
      r_fin = p_fix[WIDTH-1:0];
`endif
   end

   // ------------------------------------------------------------------
   // Iteration chain: STEPS_PER_CYCLE non-restoring steps per clock
   // ------------------------------------------------------------------
   logic [STEPS_PER_CYCLE:0][WIDTH:0]   p_chain;
   logic [STEPS_PER_CYCLE:0][WIDTH-1:0] a_chain;

   assign p_chain[0] = p_q;
   assign a_chain[0] = a_q;

   for (genvar i = 0; i < STEPS_PER_CYCLE; i++) begin : g_step
      nrda_step #(
         .WIDTH (WIDTH)
      ) u_step (
         .p     (p_chain[i]),
         .a     (a_chain[i]),
         .d     (d_q),
         .p_nxt (p_chain[i+1]),
         .a_nxt (a_chain[i+1])
      );
   end

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = y_zero ? DONE : CALC;
            end
         end
         CALC: begin
            if (cnt_q == LAST_CNT) begin
               state_d = CORR;
            end
         end
         CORR: begin
            state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            // Returning to IDLE here (rather than accepting directly) is what
            // forces a one-cycle gap between a retire and the next accept.
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q     <= '0;
         a_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         dz_q    <= 1'b0;
`ifdef NRDA_SIGNED_EN
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  p_q   <= '0;
                  a_q   <= a_init;
                  d_q   <= d_init;
                  cnt_q <= '0;
`ifdef NRDA_SIGNED_EN
                  neg_q_q <= x_neg ^ y_neg;
                  neg_r_q <= x_neg;
`endif
                  // Divide-by-zero skips the iteration entirely.
                  if (y_zero) begin
                     q_q  <= '1;
                     r_q  <= x;
                     dz_q <= 1'b1;
                  end
               end
            end
            CALC: begin
               p_q   <= p_chain[STEPS_PER_CYCLE];
               a_q   <= a_chain[STEPS_PER_CYCLE];
               cnt_q <= cnt_q + 1'b1;
            end
            CORR: begin
               p_q  <= p_fix;
               q_q  <= q_fin;
               r_q  <= r_fin;
               dz_q <= 1'b0;
            end
            DONE: begin
               // Results held until the consumer takes them.
            end
            default: begin
            end
         endcase
      end
   end

   assign q           = q_q;
   assign r           = r_q;
   assign div_by_zero = dz_q;

endmodule

// File: tb/tb_nrda_seq_div.sv
// Directed bench for nrda_seq_div: one instance with 1 step/clock, one with 2.
// Vector table on both instances, then backpressure, mid-division reset and
// random vectors; signed vectors when NRDA_SIGNED_EN is defined.
module tb_nrda_seq_div;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [1:0]   in_valid, in_ready, out_valid, out_ready, dz;
   logic [W-1:0] x, y;
   logic [W-1:0] q [2];
   logic [W-1:0] r [2];
`ifdef NRDA_SIGNED_EN
   logic         sgn;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   nrda_seq_div #(.WIDTH(W), .STEPS_PER_CYCLE(1)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .x(x), .y(y),
`ifdef NRDA_SIGNED_EN
      .sgn(sgn),
`endif
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .q(q[0]), .r(r[0]), .div_by_zero(dz[0])
   );

   nrda_seq_div #(.WIDTH(W), .STEPS_PER_CYCLE(2)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .x(x), .y(y),
`ifdef NRDA_SIGNED_EN
      .sgn(sgn),
`endif
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .q(q[1]), .r(r[1]), .div_by_zero(dz[1])
   );

   typedef struct {
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         s;
      logic [W-1:0] eq;
      logic [W-1:0] er;
      logic         edz;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   // Issue one division on instance k and wait for its result. lat counts
   // edges from the accepting edge (1) to the first edge after which
   // out_valid is seen high; it saturates at 200 on a timeout.
   task automatic run_div(input int k, input logic [W-1:0] xv, input logic [W-1:0] yv,
                          input logic sv, output logic [W-1:0] qv, output logic [W-1:0] rv,
                          output logic dzv, output int lat);
      int t;
      t = 0;
      @(negedge clk);
      while (!in_ready[k] && t < 100) begin
         @(negedge clk);
         t++;
      end
      in_valid[k] = 1'b1;
      x = xv;
      y = yv;
`ifdef NRDA_SIGNED_EN
      sgn = sv;
`else
      if (sv) t = 0;
`endif
      @(posedge clk);
      #1;
      in_valid[k] = 1'b0;
      x = $urandom;
      y = $urandom;
`ifdef NRDA_SIGNED_EN
      sgn = $urandom_range(0, 1);
`endif
      lat = 1;
      while (!out_valid[k] && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      qv  = q[k];
      rv  = r[k];
      dzv = dz[k];
   endtask

   initial begin
      vec_t         vt [$];
      logic [W-1:0] qv, rv;
      logic         dzv;
      int           lat, exp_lat;

      vt.push_back('{32'd1436,      32'd135,       1'b0, 32'd10,        32'd86,        1'b0});
      vt.push_back('{32'd100,       32'd0,         1'b0, 32'hFFFFFFFF,  32'd100,       1'b1});
      vt.push_back('{32'd5,         32'd7,         1'b0, 32'd0,         32'd5,         1'b0});
      vt.push_back('{32'hFFFFFFFF,  32'd1,         1'b0, 32'hFFFFFFFF,  32'd0,         1'b0});
      vt.push_back('{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 32'd1,         32'd0,         1'b0});
      vt.push_back('{32'd0,         32'd5,         1'b0, 32'd0,         32'd0,         1'b0});
      vt.push_back('{32'hFFFFFFFF,  32'd2,         1'b0, 32'h7FFFFFFF,  32'd1,         1'b0});
      vt.push_back('{32'h80000000,  32'd3,         1'b0, 32'h2AAAAAAA,  32'd2,         1'b0});
      vt.push_back('{32'd1000000,   32'd7,         1'b0, 32'd142857,    32'd1,         1'b0});
      vt.push_back('{32'hFFFFFFFE,  32'hFFFFFFFF,  1'b0, 32'd0,         32'hFFFFFFFE,  1'b0});
`ifdef NRDA_SIGNED_EN
      vt.push_back('{32'hFFFFFA64,  32'd135,       1'b1, 32'hFFFFFFF6,  32'hFFFFFFAA,  1'b0});
      vt.push_back('{32'h80000000,  32'hFFFFFFFF,  1'b1, 32'h80000000,  32'd0,         1'b0});
      vt.push_back('{32'd7,         32'hFFFFFFFE,  1'b1, 32'hFFFFFFFD,  32'd1,         1'b0});
      vt.push_back('{32'hFFFFFFF9,  32'hFFFFFFFE,  1'b1, 32'd3,         32'hFFFFFFFF,  1'b0});
      vt.push_back('{32'hFFFFFFF9,  32'd0,         1'b1, 32'hFFFFFFFF,  32'hFFFFFFF9,  1'b1});
      sgn = 1'b0;
`endif

      rst_n     = 1'b0;
      in_valid  = 2'b00;
      out_ready = 2'b11;
      x         = '0;
      y         = '0;

      // Reset state
      #2;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("reset in_ready[%0d]", k),  64'(in_ready[k]),  64'd1);
         check($sformatf("reset out_valid[%0d]", k), 64'(out_valid[k]), 64'd0);
         check($sformatf("reset q[%0d]", k),         64'(q[k]),         64'd0);
         check($sformatf("reset r[%0d]", k),         64'(r[k]),         64'd0);
         check($sformatf("reset dz[%0d]", k),        64'(dz[k]),        64'd0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Vector table on both instances
      foreach (vt[i]) begin
         for (int k = 0; k < 2; k++) begin
            run_div(k, vt[i].x, vt[i].y, vt[i].s, qv, rv, dzv, lat);
            exp_lat = vt[i].edz ? 1 : ((k == 0) ? 34 : 18);
            check($sformatf("vec%0d q[%0d]", i, k),   64'(qv),  64'(vt[i].eq));
            check($sformatf("vec%0d r[%0d]", i, k),   64'(rv),  64'(vt[i].er));
            check($sformatf("vec%0d dz[%0d]", i, k),  64'(dzv), 64'(vt[i].edz));
            check($sformatf("vec%0d lat[%0d]", i, k), 64'(lat), 64'(exp_lat));
         end
      end

      // Backpressure: hold out_ready low 5 cycles while offering a new operand
      out_ready[0] = 1'b0;
      run_div(0, 32'd1436, 32'd135, 1'b0, qv, rv, dzv, lat);
      check("bp q", 64'(qv), 64'd10);
      check("bp lat", 64'(lat), 64'd34);
      in_valid[0] = 1'b1;
      x = 32'd7;
      y = 32'd0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("bp%0d out_valid", c), 64'(out_valid[0]), 64'd1);
         check($sformatf("bp%0d q", c),         64'(q[0]),         64'd10);
         check($sformatf("bp%0d r", c),         64'(r[0]),         64'd86);
         check($sformatf("bp%0d in_ready", c),  64'(in_ready[0]),  64'd0);
      end
      @(negedge clk);
      out_ready[0] = 1'b1;
      in_valid[0]  = 1'b0;
      @(posedge clk);
      #1;
      check("bp release out_valid", 64'(out_valid[0]), 64'd0);
      check("bp release in_ready",  64'(in_ready[0]),  64'd1);
      check("bp release q held",    64'(q[0]),         64'd10);
      check("bp release dz",        64'(dz[0]),        64'd0);

      // Asynchronous reset in the middle of CALC
      @(negedge clk);
      in_valid[0] = 1'b1;
      x = 32'd1436;
      y = 32'd135;
      @(posedge clk);
      #1;
      in_valid[0] = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset in_ready",  64'(in_ready[0]),  64'd1);
      check("midreset out_valid", 64'(out_valid[0]), 64'd0);
      check("midreset q",         64'(q[0]),         64'd0);
      check("midreset r",         64'(r[0]),         64'd0);
      check("midreset dz",        64'(dz[0]),        64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_div(0, 32'd1436, 32'd135, 1'b0, qv, rv, dzv, lat);
      check("postreset q",   64'(qv),  64'd10);
      check("postreset r",   64'(rv),  64'd86);
      check("postreset dz",  64'(dzv), 64'd0);
      check("postreset lat", 64'(lat), 64'd34);

      // Random unsigned vectors against x / y, x % y
      for (int i = 0; i < 150; i++) begin
         logic [W-1:0] xv, yv;
         xv = $urandom;
         yv = $urandom >> $urandom_range(0, 31);
         if (yv == '0) yv = 32'd1;
         run_div(1, xv, yv, 1'b0, qv, rv, dzv, lat);
         check($sformatf("rnd%0d q %h/%h", i, xv, yv), 64'(qv), 64'(xv / yv));
         check($sformatf("rnd%0d r %h/%h", i, xv, yv), 64'(rv), 64'(xv % yv));
      end

`ifdef NRDA_SIGNED_EN
      // Random signed vectors; truncating division of the bench's signed operands
      for (int i = 0; i < 300; i++) begin
         logic signed [W-1:0] xs, ys, eq, er;
         xs = $urandom;
         ys = $signed($urandom) >>> $urandom_range(0, 31);
         if (ys == 0) ys = -3;
         if (xs == 32'sh80000000 && ys == -1) ys = -2;
         eq = xs / ys;
         er = xs % ys;
         run_div(1, xs, ys, 1'b1, qv, rv, dzv, lat);
         check($sformatf("srnd%0d q %h/%h", i, xs, ys), 64'(qv), 64'(eq));
         check($sformatf("srnd%0d r %h/%h", i, xs, ys), 64'(rv), 64'(er));
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
